// File: rtl/pio_in_scanner_pkg.sv
// Shared constants for the PIO input scanner: register map, FSM encoding,
// CTRL field layout and the period helper.
package pio_in_scanner_pkg;

  // CPU register addresses
  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_EDGE  = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // Scan FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  // CTRL field layout
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_PERIOD_LSB = 16;
  localparam int CTRL_PERIOD_W   = 16;

  // A programmed period of 0 behaves like 1 (scan tick every cycle).
  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/pio_in_scanner_if.sv
// Avalon-MM slave bus between the CPU and the scanner's register file.
interface pio_in_scanner_if;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  modport master (
    output s_address, s_read, s_write, s_writedata,
    input  s_readdata
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata,
    output s_readdata
  );
endinterface

// File: rtl/pio_in_scanner_debounce_bit.sv
// One debounced input bit: a small run-length counter of samples that
// disagree with the stable value, the stable flop, and a rise pulse that
// is high in the same cycle the stable value flips 0->1.
module pio_debounce_bit #(
  parameter int DEB_COUNT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic rise
);

  logic [2:0] cnt;
  logic [2:0] cnt_inc;
  logic       flip;

  assign cnt_inc = cnt + 3'd1;
  assign flip    = sample_en && (sample != stable) && (cnt_inc == 3'(DEB_COUNT));
  assign rise    = flip && !stable;

  // Count disagreeing samples; flip the stable value once enough accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 3'd0;
      stable <= 1'b0;
    end else if (sample_en) begin
      if (sample == stable) begin
        cnt <= 3'd0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= 3'd0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/pio_in_scanner.sv
// Round-robin poller for up to four 4-bit PIO input slaves. A period
// counter launches scans; each channel gets a settle cycle for the shared
// readdata mux followed by a sample cycle. Debounced state, sticky rising
// edges, an irq mask and CTRL are exposed on an Avalon-MM slave.
module pio_in_scanner
  import pio_in_scanner_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CH_W       = 4,
  parameter int          DEB_COUNT  = 3,
  parameter logic [15:0] PERIOD_RST = 16'd1000
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [1:0]         pio_chan,
  output logic [1:0]         pio_address,
  input  logic [31:0]        pio_readdata,
  pio_in_scanner_if.slave    s,
  output logic               irq
);

  localparam int NB = NUM_CH * CH_W;

  logic                      ctrl_en;
  logic [CTRL_PERIOD_W-1:0]  ctrl_period;
  logic [15:0]               per_cnt;
  logic [15:0]               period_last;
  logic                      tick;
  logic [1:0]                fsm;
  logic                      sample_go;
  logic [NB-1:0]             stable_bits;
  logic [NB-1:0]             rise_bits;
  logic [NB-1:0]             edge_q;
  logic [NB-1:0]             mask_q;
  logic [NB-1:0]             w1c;
  logic [31:0]               rdata;
  logic                      wr_ctrl;
  logic                      wr_edge;
  logic                      wr_mask;
  logic                      bits_unused;

  assign wr_ctrl = s.s_write && (s.s_address == REG_CTRL);
  assign wr_edge = s.s_write && (s.s_address == REG_EDGE);
  assign wr_mask = s.s_write && (s.s_address == REG_MASK);

  // Only the low CH_W readdata bits and part of the write data carry meaning.
  assign bits_unused = ^{pio_readdata, s.s_writedata};

  assign pio_address = 2'b00;

  // CTRL register: enable bit plus scan period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_period <= PERIOD_RST;
    end else if (wr_ctrl) begin
      ctrl_en     <= s.s_writedata[CTRL_EN_BIT];
      ctrl_period <= s.s_writedata[CTRL_PERIOD_LSB +: CTRL_PERIOD_W];
    end
  end

  // Tick is suppressed on a CTRL write so the new period starts cleanly.
  assign period_last = eff_period(ctrl_period) - 16'd1;
  assign tick        = ctrl_en && !wr_ctrl && (per_cnt == period_last);

  // Free-running period counter, held while disabled, cleared by CTRL writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= 16'd0;
    end else if (wr_ctrl) begin
      per_cnt <= 16'd0;
    end else if (ctrl_en) begin
      per_cnt <= (per_cnt == period_last) ? 16'd0 : per_cnt + 16'd1;
    end
  end

  // Scan sequencer. Enable only gates ticks, so a scan in flight always
  // runs to the last channel; ticks outside IDLE are simply lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= ST_IDLE;
      pio_chan <= 2'd0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (tick) begin
            pio_chan <= 2'd0;
            fsm      <= ST_SETTLE;
          end
        end
        ST_SETTLE: fsm <= ST_SAMPLE;
        ST_SAMPLE: begin
          if (pio_chan == 2'(NUM_CH - 1)) begin
            pio_chan <= 2'd0;
            fsm      <= ST_IDLE;
          end else begin
            pio_chan <= pio_chan + 2'd1;
            fsm      <= ST_SETTLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign sample_go = (fsm == ST_SAMPLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar b = 0; b < CH_W; b++) begin : g_bit
      pio_debounce_bit #(
        .DEB_COUNT (DEB_COUNT)
      ) u_deb (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_go && (pio_chan == 2'(c))),
        .sample    (pio_readdata[b]),
        .stable    (stable_bits[c*CH_W + b]),
        .rise      (rise_bits[c*CH_W + b])
      );
    end
  end

  assign w1c = wr_edge ? s.s_writedata[NB-1:0] : '0;

  // Sticky edge flags: write-1-to-clear, with a same-cycle rise winning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~w1c) | rise_bits;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (wr_mask) begin
      mask_q <= s.s_writedata[NB-1:0];
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= 32'd0;
    end else if (s.s_read) begin
      case (s.s_address)
        REG_STATE: rdata <= 32'(stable_bits);
        REG_EDGE:  rdata <= 32'(edge_q);
        REG_MASK:  rdata <= 32'(mask_q);
        default:   rdata <= {ctrl_period, 15'd0, ctrl_en};
      endcase
    end
  end

  assign s.s_readdata = rdata;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_in_scanner.sv
// Bench for pio_in_scanner: PIO inputs are modelled as per-channel nibbles
// behind a one-cycle-late readdata mux; a scan-level reference model tracks
// debounced state and edge flags.
module tb_pio_in_scanner;
  import pio_in_scanner_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 4;
  localparam int DEB    = 3;
  localparam int NB     = NUM_CH * CH_W;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_chan;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic        irq;

  pio_in_scanner_if bus();

  pio_in_scanner #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .DEB_COUNT  (DEB),
    .PERIOD_RST (16'd1000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_chan     (pio_chan),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .s            (bus),
    .irq          (irq)
  );

  int total = 0;
  int bad   = 0;

  logic [CH_W-1:0] in_port [NUM_CH];
  int              m_st  [NB];
  int              m_cnt [NB];
  logic [31:0]     m_edge;
  logic [31:0]     m_mask;

  always #5 clk = ~clk;

  // Selected PIO data appears one cycle after pio_chan moves; upper bits are noise.
  always @(posedge clk)
    pio_readdata <= ($urandom() & 32'hFFFF_FFF0) | {28'd0, in_port[pio_chan]};

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.s_address   = a;
    bus.s_writedata = d;
    bus.s_write     = 1'b1;
    @(negedge clk);
    bus.s_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.s_address = a;
    bus.s_read    = 1'b1;
    @(negedge clk);
    bus.s_read    = 1'b0;
    d = bus.s_readdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i]  = 0;
      m_cnt[i] = 0;
    end
    m_edge = 32'd0;
    m_mask = 32'd0;
    for (int c = 0; c < NUM_CH; c++) in_port[c] = '0;
  endtask

  // One full scan: every bit sees its channel's current nibble once.
  task automatic model_scan();
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < CH_W; b++) begin
        int i;
        int smp;
        i   = c * CH_W + b;
        smp = int'(in_port[c][b]);
        if (smp == m_st[i]) m_cnt[i] = 0;
        else begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_st[i]  = smp;
            m_cnt[i] = 0;
            if (smp == 1) m_edge[i] = 1'b1;
          end
        end
      end
  endtask

  function automatic logic [31:0] model_state();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < NB; i++) v[i] = (m_st[i] != 0);
    return v;
  endfunction

  task automatic apply_reset();
    bus.s_read  = 1'b0;
    bus.s_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_scans(input int n, output bit ok);
    int         seen;
    logic [1:0] prev;
    seen = 0;
    ok   = 1'b0;
    prev = pio_chan;
    for (int cyc = 0; cyc < 400 * n; cyc++) begin
      @(negedge clk);
      if (prev == 2'(NUM_CH - 1) && pio_chan == 2'd0) seen++;
      prev = pio_chan;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Enable scanning for exactly n scans, then park the scanner disabled.
  task automatic run_scans(input int n);
    bit ok;
    cpu_write(REG_CTRL, {16'd20, 16'd1});
    wait_scans(n, ok);
    cpu_write(REG_CTRL, {16'd20, 16'd0});
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL scan_timeout: got no completion, wanted %0d scans", n);
    end
    repeat (n) model_scan();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit          found;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++; if (pio_chan !== 2'd0)   begin bad++; $display("FAIL rst_chan: got %0d want 0", pio_chan); end
    total++; if (irq !== 1'b0)        begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    total++; if (bus.s_readdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.s_readdata); end
    // Build up non-zero state, then reset in the middle of a scan.
    cpu_write(REG_MASK, 32'h0000_000F);
    in_port[0] = 4'hF;
    run_scans(3);
    cpu_read(REG_EDGE, d);
    total++; if (d !== 32'h0000_000F) begin bad++; $display("FAIL pre_rst_edge: got %h want 0000000f", d); end
    cpu_write(REG_CTRL, {16'd4, 16'd1});
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (pio_chan == 2'd2) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_midscan_wait: got no pio_chan=2 want chan 2 within 100 cycles"); end
    reset_n = 1'b0;
    #1;
    total++; if (pio_chan !== 2'd0) begin bad++; $display("FAIL rst_async_chan: got %0d want 0", pio_chan); end
    total++; if (irq !== 1'b0)      begin bad++; $display("FAIL rst_async_irq: got %b want 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cpu_read(REG_STATE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_state: got %h want 0", d); end
    cpu_read(REG_EDGE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_edge: got %h want 0", d); end
    cpu_read(REG_MASK, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_mask: got %h want 0", d); end
    cpu_read(REG_CTRL, d);
    total++; if (d !== 32'h03E8_0000) begin bad++; $display("FAIL rst_ctrl: got %h want 03e80000", d); end
    repeat (3) @(negedge clk);
    total++; if (bus.s_readdata !== 32'h03E8_0000) begin bad++; $display("FAIL rdata_hold: got %h want 03e80000", bus.s_readdata); end
    total++; if (pio_chan !== 2'd0 || pio_address !== 2'd0) begin bad++; $display("FAIL rst_idle_chan: got chan %0d addr %0d want 0 0", pio_chan, pio_address); end
  endtask

  // Channel sequence, hold times and scan restart spacing for a given period.
  task automatic test_scan_timing(input int p);
    localparam int TR = 100;
    logic [1:0] tr [TR];
    int         addr_err;
    int         starts [$];
    int         run_start;
    int         exp_gap;
    apply_reset();
    // A tick in the cycle the last channel is sampled is lost, so the next
    // scan starts on the first tick strictly after 2*NUM_CH busy cycles.
    exp_gap = p * ((2 * NUM_CH) / p + 1);
    cpu_write(REG_CTRL, {16'(p), 16'd1});
    addr_err = 0;
    for (int t = 0; t < TR; t++) begin
      @(negedge clk);
      tr[t] = pio_chan;
      if (pio_address !== 2'd0) addr_err++;
    end
    cpu_write(REG_CTRL, 32'd0);
    repeat (2 * NUM_CH + 2) @(negedge clk);
    total++; if (addr_err != 0) begin bad++; $display("FAIL pio_address: got %0d nonzero cycles want 0", addr_err); end
    run_start = 0;
    for (int t = 1; t < TR; t++) begin
      if (tr[t] != tr[t-1]) begin
        total++;
        if (tr[t] !== 2'((tr[t-1] + 1) % NUM_CH)) begin
          bad++; $display("FAIL chan_seq p=%0d t=%0d: got %0d after %0d want %0d", p, t, tr[t], tr[t-1], (tr[t-1] + 1) % NUM_CH);
        end
        if (run_start > 0 && tr[t-1] != 2'd0) begin
          total++;
          if (t - run_start != 2) begin bad++; $display("FAIL chan_hold p=%0d chan=%0d: got %0d cycles want 2", p, tr[t-1], t - run_start); end
        end
        if (tr[t] == 2'd1) starts.push_back(t);
        run_start = t;
      end
    end
    total++; if (starts.size() < 3) begin bad++; $display("FAIL scan_count p=%0d: got %0d scans want at least 3", p, starts.size()); end
    for (int i = 1; i < starts.size(); i++) begin
      total++;
      if (starts[i] - starts[i-1] != exp_gap) begin
        bad++; $display("FAIL scan_gap p=%0d: got %0d want %0d", p, starts[i] - starts[i-1], exp_gap);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    apply_reset();
    in_port[1] = 4'b0101;
    run_scans(2);
    in_port[1] = 4'b0000;
    run_scans(1);
    cpu_read(REG_STATE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL deb_short: got %h want 0", d); end
    in_port[1] = 4'b0101;
    run_scans(3);
    cpu_read(REG_STATE, d);
    total++; if (d !== 32'h0000_0050) begin bad++; $display("FAIL deb_long: got %h want 00000050", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] w;
    apply_reset();
    m_mask = $urandom() & 32'h0000_FFFF;
    cpu_write(REG_MASK, m_mask);
    for (int it = 0; it < 24; it++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 2) == 0) in_port[c] = 4'($urandom());
      run_scans($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom();
        cpu_write(REG_EDGE, w);
        m_edge = m_edge & ~w;
      end
      if ($urandom_range(0, 5) == 0) begin
        m_mask = $urandom();
        cpu_write(REG_MASK, m_mask);
        m_mask = m_mask & 32'h0000_FFFF;
      end
      cpu_read(REG_STATE, d);
      total++; if (d !== model_state()) begin bad++; $display("FAIL rnd_state it=%0d: got %h want %h", it, d, model_state()); end
      cpu_read(REG_EDGE, d);
      total++; if (d !== m_edge) begin bad++; $display("FAIL rnd_edge it=%0d: got %h want %h", it, d, m_edge); end
      total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL rnd_irq it=%0d: got %b want %b", it, irq, |(m_edge & m_mask)); end
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    apply_reset();
    cpu_write(REG_MASK, 32'h0000_0001);
    in_port[0] = 4'b0001;
    run_scans(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
    run_scans(1);
    cpu_read(REG_EDGE, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL edge_set: got %h want 00000001", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
    cpu_write(REG_EDGE, 32'h0000_0001);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr: got %b want 0", irq); end
    in_port[0] = 4'b0000;
    run_scans(3);
    cpu_read(REG_STATE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL fall_state: got %h want 0", d); end
    cpu_read(REG_EDGE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL fall_edge: got %h want 0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_irq: got %b want 0", irq); end
  endtask

  // W1C timed against the sample cycle of the third agreeing ch0 sample:
  // in the same cycle the set wins, one cycle later the clear wins.
  task automatic test_simultaneous(input int late, input logic [31:0] want);
    localparam int P = 4;
    logic [31:0] d;
    apply_reset();
    in_port[0] = 4'b0001;
    run_scans(2);
    cpu_write(REG_CTRL, {16'(P), 16'd1});
    repeat (P + 1 + late) @(negedge clk);
    bus.s_address   = REG_EDGE;
    bus.s_writedata = 32'h0000_0001;
    bus.s_write     = 1'b1;
    @(negedge clk);
    bus.s_write     = 1'b0;
    cpu_write(REG_CTRL, 32'd0);
    repeat (2 * NUM_CH + 2) @(negedge clk);
    cpu_read(REG_EDGE, d);
    total++; if (d !== want) begin bad++; $display("FAIL simul_w1c late=%0d: got %h want %h", late, d, want); end
    cpu_read(REG_STATE, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL simul_state late=%0d: got %h want 00000001", late, d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bit          found;
    bit          saw_last;
    bit          back_idle;
    int          extra;
    logic [1:0]  prev;
    apply_reset();
    cpu_write(REG_CTRL, {16'd20, 16'd1});
    found = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (pio_chan == 2'd1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL dis_wait: got no pio_chan=1 want chan 1 within 200 cycles"); end
    bus.s_address   = REG_CTRL;
    bus.s_writedata = {16'd20, 16'd0};
    bus.s_write     = 1'b1;
    @(negedge clk);
    bus.s_write = 1'b0;
    saw_last  = 1'b0;
    back_idle = 1'b0;
    extra     = 0;
    prev      = pio_chan;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (back_idle && pio_chan != 2'd0) extra++;
      if (pio_chan == 2'(NUM_CH - 1)) saw_last = 1'b1;
      if (saw_last && prev == 2'(NUM_CH - 1) && pio_chan == 2'd0) back_idle = 1'b1;
      prev = pio_chan;
    end
    total++; if (!(saw_last && back_idle)) begin bad++; $display("FAIL dis_finish: got last=%b idle=%b want 1 1", saw_last, back_idle); end
    total++; if (extra != 0) begin bad++; $display("FAIL dis_quiet: got %0d active cycles want 0", extra); end
    cpu_read(REG_CTRL, d);
    total++; if (d !== 32'h0014_0000) begin bad++; $display("FAIL dis_ctrl: got %h want 00140000", d); end
  endtask

  initial begin
    bus.s_address   = 2'd0;
    bus.s_read      = 1'b0;
    bus.s_write     = 1'b0;
    bus.s_writedata = 32'd0;
    for (int c = 0; c < NUM_CH; c++) in_port[c] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_scan_timing(4);
    test_scan_timing($urandom_range(1, 12));
    test_debounce();
    test_edge_irq();
    test_simultaneous(0, 32'h0000_0001);
    test_simultaneous(1, 32'h0000_0000);
    test_random();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
